// File: rtl/input_sample_fifo_pkg.sv
// fir_pkg: shared FIR datapath sample width, FIFO depth and sample type
package fir_pkg;
  localparam int SAMPLE_W = 32;
  localparam int FIFO_DEPTH = 8;
  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/input_sample_fifo_if.sv
// input_sample_fifo_if: push/pull handshake and status bundle between host, fifo and control_fsm
interface input_sample_fifo_if
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH = FIFO_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic              PushIn;
  logic [DATA_W-1:0] DataIn;
  logic              fifoPullOut;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] DataOut;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  modport master (
    output PushIn, DataIn, fifoPullOut,
    input  fifo_empty, fifo_full, DataOut, count, overflow, underflow
  );
  modport slave (
    input  PushIn, DataIn, fifoPullOut,
    output fifo_empty, fifo_full, DataOut, count, overflow, underflow
  );
endinterface

// File: rtl/input_sample_fifo.sv
// input_sample_fifo: FWFT circular sample buffer feeding control_fsm, wrap-bit pointers, sticky error flags
module input_sample_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  input_sample_fifo_if.slave bus
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr;
  logic [ADDR_W:0]   r_rd;
  logic              r_ovf;
  logic              r_udf;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pull;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[ADDR_W-1:0] == r_rd[ADDR_W-1:0]) && (r_wr[ADDR_W] != r_rd[ADDR_W]);
  // a same-cycle pull frees the slot, so a push into a full buffer is still taken then
  assign w_push  = bus.PushIn && (!w_full || bus.fifoPullOut);
  assign w_pull  = bus.fifoPullOut && !w_empty;
  assign bus.fifo_empty = w_empty;
  assign bus.fifo_full  = w_full;
  assign bus.count      = r_wr - r_rd;
  assign bus.DataOut    = r_mem[r_rd[ADDR_W-1:0]];
  assign bus.overflow   = r_ovf;
  assign bus.underflow  = r_udf;
  // pointer advance, sample capture and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[ADDR_W-1:0]] <= bus.DataIn;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pull) r_rd <= r_rd + 1'b1;
      if (bus.PushIn && w_full && !bus.fifoPullOut) r_ovf <= 1'b1;
      if (bus.fifoPullOut && w_empty) r_udf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_input_sample_fifo.sv
// tb_input_sample_fifo: directed and random checks against a queue-based model of the sample FIFO
module tb_input_sample_fifo;
  import fir_pkg::*;
  localparam int DEPTH = FIFO_DEPTH;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  sample_t q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  input_sample_fifo_if #(.DATA_W(SAMPLE_W), .DEPTH(DEPTH)) bus();
  input_sample_fifo #(.DATA_W(SAMPLE_W), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ":empty"}, 32'(bus.fifo_empty), 32'(q.size() == 0));
    chk({tag, ":full"}, 32'(bus.fifo_full), 32'(q.size() == DEPTH));
    chk({tag, ":overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ":underflow"}, 32'(bus.underflow), 32'(m_udf));
    if (q.size() != 0) chk({tag, ":data"}, bus.DataOut, q[0]);
  endtask

  // one clock of stimulus; the model applies the buffer rules to its own queue
  task automatic step(input bit push, input sample_t d, input bit pull, input string tag);
    bit full;
    bit empty;
    bus.PushIn = push;
    bus.DataIn = d;
    bus.fifoPullOut = pull;
    full = q.size() == DEPTH;
    empty = q.size() == 0;
    if (pull && empty) m_udf = 1'b1;
    if (push && full && !pull) m_ovf = 1'b1;
    if (pull && !empty) void'(q.pop_front());
    if (push && (!full || pull)) q.push_back(d);
    @(posedge clk);
    #1;
    bus.PushIn = 1'b0;
    bus.fifoPullOut = 1'b0;
    check_all(tag);
  endtask

  // asserts reset between edges, checks the async clear, releases on a falling edge
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk({tag, ":rst_data"}, bus.DataOut, 32'h0);
    check_all(tag);
    bus.PushIn = 1'b0;
    bus.fifoPullOut = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.PushIn = 1'b0;
    bus.DataIn = '0;
    bus.fifoPullOut = 1'b0;
    do_reset("reset0");
    step(1, 32'h11, 0, "push11");
    step(1, 32'h22, 0, "push22");
    step(1, 32'h33, 0, "push33");
    step(1, 32'h44, 0, "push44");
    for (int k = 0; k < 4; k++) step(0, 32'h0, 1, "pull4");
    for (int k = 1; k <= 8; k++) step(1, sample_t'(k), 0, "fill8");
    step(1, 32'h9, 0, "push9_ovf");
    for (int k = 0; k < 8; k++) step(0, 32'h0, 1, "drain8");
    do_reset("reset1");
    for (int k = 1; k <= 8; k++) step(1, sample_t'(k), 0, "refill8");
    step(1, 32'hA5, 1, "full_pushpull");
    for (int k = 0; k < 8; k++) step(0, 32'h0, 1, "drain_a5");
    step(1, 32'h5A, 1, "empty_pushpull");
    for (int k = 0; k < 20; k++) step(1, sample_t'(32'h100 + k), 1, "wrap_pairs");
    for (int k = 0; k < 300; k++) begin
      bit push;
      bit pull;
      push = (k < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      pull = (k < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(push, sample_t'($urandom), pull, "random");
    end
    do_reset("reset2");
    for (int k = 0; k < 5; k++) step(1, sample_t'(32'hC0 + k), 0, "pre_mid");
    bus.PushIn = 1'b1;
    bus.DataIn = 32'hDEAD;
    #2;
    do_reset("mid_reset");
    step(1, 32'h77, 0, "post_rst77");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
